matrix_mem_controller: RTL and testbench

Memory-side sequencer for the parallel matrix multiplier CPU. On a start command it reads operand matrices A and B (DIM×DIM words each) out of the single-port main memory and streams them to the multiplier over a valid/ready channel. It then accepts the DIM×DIM result words from the multiplier and writes them back to matrix C in the same memory. It is the only master on the main-memory port while busy.

---
 rtl/matrix_mem_controller_pkg.sv | 47 ++++
 rtl/matrix_mem_controller_if.sv | 69 ++++++
 rtl/matrix_mem_controller_addr_gen.sv | 75 +++++++
 rtl/matrix_mem_controller.sv | 214 +++++++++++++++++++++
 tb/tb_matrix_mem_controller.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_mem_controller_pkg.sv
// ---------------------------------------------------------------------------
// matrix_mem_pkg
//
// Shared definitions for the matrix multiplier memory-side sequencer:
//   - default geometry (DEF_DIM, DEF_ADDR_W, DEF_DATA_W, DEF_WORDS)
//   - operand select encodings (OP_SEL_A / OP_SEL_B)
//   - controller state enum and address-generator phase enum
//   - idxWidth helper used to size row-major word indices
// ---------------------------------------------------------------------------
package matrix_mem_pkg;

    localparam int DEF_DIM    = 4;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_WORDS  = DEF_DIM * DEF_DIM;

    // Tag carried with every operand word so the multiplier knows which
    // matrix the word belongs to.
    localparam logic OP_SEL_A = 1'b0;
    localparam logic OP_SEL_B = 1'b1;

    // Controller sequence: read A then B word by word, collect results, then
    // write them to C.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_OUT,
        ST_WR_ACC,
        ST_WR_MEM,
        ST_DONE
    } ctrl_state_e;

    // Which base address the address generator adds the word counter to.
    typedef enum logic [1:0] {
        PHASE_A,
        PHASE_B,
        PHASE_C
    } addr_phase_e;

    // Width of a row-major index; kept at least one bit wide so a 1x1 matrix
    // still gets a legal vector.
    function automatic int idxWidth(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/matrix_mem_controller_if.sv
// ---------------------------------------------------------------------------
// matrix_mem_controller_if
//
// Bundles the three channels the sequencer talks on:
//   - operand stream to the multiplier : op_valid/op_ready/op_data/op_sel/op_index
//   - result stream from the multiplier: res_valid/res_ready/res_data
//   - single-port main memory          : mem_write_readBar/mem_address/
//                                        mem_wdata/mem_rdata
// Modports:
//   master - the controller side (drives op_*, res_ready, mem_* requests)
//   slave  - the environment side (multiplier + memory)
// ---------------------------------------------------------------------------
interface matrix_mem_controller_if
    import matrix_mem_pkg::*;
#(
    parameter int DIM    = DEF_DIM,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    localparam int WORDS = DIM * DIM;
    localparam int IDX_W = idxWidth(WORDS);

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_data;
    logic              op_sel;
    logic [IDX_W-1:0]  op_index;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    logic              mem_write_readBar;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output op_valid,
        input  op_ready,
        output op_data,
        output op_sel,
        output op_index,
        input  res_valid,
        output res_ready,
        input  res_data,
        output mem_write_readBar,
        output mem_address,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  op_valid,
        output op_ready,
        input  op_data,
        input  op_sel,
        input  op_index,
        output res_valid,
        input  res_ready,
        output res_data,
        input  mem_write_readBar,
        input  mem_address,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/matrix_mem_controller_addr_gen.sv
// ---------------------------------------------------------------------------
// mem_addr_gen
//
// Word counter and address generator for the matrix memory sequencer.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   kClear_i        - restart the word counter at 0 (takes priority)
//   kInc_i          - advance the word counter by one
//   phase_i         - selects base A, B or C
//   baseA_i/B_i/C_i - latched base word addresses
//   address_o       - base + k, wrapping modulo 2^ADDR_W
//   k_o             - current row-major word index
//   lastWord_o      - k is the final word of a matrix
// ---------------------------------------------------------------------------
module mem_addr_gen
    import matrix_mem_pkg::*;
#(
    parameter int WORDS  = DEF_WORDS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IDX_W  = idxWidth(WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              kClear_i,
    input  logic              kInc_i,
    input  addr_phase_e       phase_i,
    input  logic [ADDR_W-1:0] baseA_i,
    input  logic [ADDR_W-1:0] baseB_i,
    input  logic [ADDR_W-1:0] baseC_i,
    output logic [ADDR_W-1:0] address_o,
    output logic [IDX_W-1:0]  k_o,
    output logic              lastWord_o
);

    logic [IDX_W-1:0]  k_q;
    logic [IDX_W-1:0]  k_d;
    logic [ADDR_W-1:0] base;

    // Next value of the word counter. Clear wins over increment so that the
    // controller can restart a matrix on the same cycle it finishes one.
    always_comb begin
        k_d = k_q;
        if (kClear_i) begin
            k_d = '0;
        end else if (kInc_i) begin
            k_d = k_q + 1'b1;
        end
    end

    // Word counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    // Pick the base for the current phase. The add is left at ADDR_W bits so
    // addresses past the top of memory silently wrap to 0.
    always_comb begin
        base = baseA_i;
        unique case (phase_i)
            PHASE_A: base = baseA_i;
            PHASE_B: base = baseB_i;
            PHASE_C: base = baseC_i;
            default: base = baseA_i;
        endcase
    end

    assign address_o  = base + ADDR_W'(k_q);
    assign k_o        = k_q;
    assign lastWord_o = (k_q == IDX_W'(WORDS - 1));

endmodule

// File: rtl/matrix_mem_controller.sv
// ---------------------------------------------------------------------------
// matrix_mem_controller
//
// Memory-side sequencer for the parallel matrix multiplier. On start it reads
// A then B (WORDS words each) from main memory and streams them over the
// operand channel, then accepts WORDS result words and writes them to C.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   start                  - begin an operation (only looked at while idle)
//   base_a, base_b, base_c - base word addresses, captured with start
//   busy                   - operation in progress
//   done                   - one-cycle pulse after the last write
//   bus                    - operand / result / memory channels (master side)
// ---------------------------------------------------------------------------
module matrix_mem_controller
    import matrix_mem_pkg::*;
#(
    parameter int DIM    = DEF_DIM,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_a,
    input  logic [ADDR_W-1:0]        base_b,
    input  logic [ADDR_W-1:0]        base_c,
    output logic                     busy,
    output logic                     done,
    matrix_mem_controller_if.master  bus
);

    localparam int WORDS = DIM * DIM;
    localparam int IDX_W = idxWidth(WORDS);

    ctrl_state_e       state_q,   state_d;
    logic              sel_q,     sel_d;
    logic [ADDR_W-1:0] baseA_q,   baseA_d;
    logic [ADDR_W-1:0] baseB_q,   baseB_d;
    logic [ADDR_W-1:0] baseC_q,   baseC_d;
    logic [DATA_W-1:0] opData_q,  opData_d;
    logic              opSel_q,   opSel_d;
    logic [IDX_W-1:0]  opIndex_q, opIndex_d;
    logic [DATA_W-1:0] resWord_q, resWord_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;

    logic              kClear;
    logic              kInc;
    addr_phase_e       phase;
    logic [ADDR_W-1:0] genAddr;
    logic [IDX_W-1:0]  k;
    logic              lastWord;
    logic              addrLive;

    mem_addr_gen #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_addrGen (
        .clk        (clk),
        .reset      (reset),
        .kClear_i   (kClear),
        .kInc_i     (kInc),
        .phase_i    (phase),
        .baseA_i    (baseA_q),
        .baseB_i    (baseB_q),
        .baseC_i    (baseC_q),
        .address_o  (genAddr),
        .k_o        (k),
        .lastWord_o (lastWord)
    );

    // The write-back phase always addresses C; during reads the operand
    // select decides between A and B.
    always_comb begin
        phase = PHASE_A;
        if (state_q == ST_WR_ACC || state_q == ST_WR_MEM) begin
            phase = PHASE_C;
        end else if (sel_q == OP_SEL_B) begin
            phase = PHASE_B;
        end
    end

    // The memory address only moves in the two states that actually access
    // memory. Everywhere else the last presented address is held, so a
    // stalled handshake never shows a fresh read address to the memory.
    always_comb begin
        addrLive  = (state_q == ST_RD_ADDR) || (state_q == ST_WR_MEM);
        memAddr_d = addrLive ? genAddr : memAddr_q;
    end

    // Next-state and datapath control. Every register holds by default; each
    // state only overrides what it changes. The counter is cleared rather
    // than incremented when a matrix ends so the next matrix starts at 0.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        baseA_d   = baseA_q;
        baseB_d   = baseB_q;
        baseC_d   = baseC_q;
        opData_d  = opData_q;
        opSel_d   = opSel_q;
        opIndex_d = opIndex_q;
        resWord_d = resWord_q;
        kClear    = 1'b0;
        kInc      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    baseA_d = base_a;
                    baseB_d = base_b;
                    baseC_d = base_c;
                    sel_d   = OP_SEL_A;
                    kClear  = 1'b1;
                    state_d = ST_RD_ADDR;
                end
            end

            ST_RD_ADDR: begin
                state_d = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                opData_d  = bus.mem_rdata;
                opIndex_d = k;
                opSel_d   = sel_q;
                state_d   = ST_RD_OUT;
            end

            ST_RD_OUT: begin
                if (bus.op_ready) begin
                    if (lastWord && sel_q == OP_SEL_A) begin
                        sel_d   = OP_SEL_B;
                        kClear  = 1'b1;
                        state_d = ST_RD_ADDR;
                    end else if (lastWord) begin
                        kClear  = 1'b1;
                        state_d = ST_WR_ACC;
                    end else begin
                        kInc    = 1'b1;
                        state_d = ST_RD_ADDR;
                    end
                end
            end

            ST_WR_ACC: begin
                if (bus.res_valid) begin
                    resWord_d = bus.res_data;
                    state_d   = ST_WR_MEM;
                end
            end

            ST_WR_MEM: begin
                if (lastWord) begin
                    state_d = ST_DONE;
                end else begin
                    kInc    = 1'b1;
                    state_d = ST_WR_ACC;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any in-flight operand or
    // result and returns every visible output to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= OP_SEL_A;
            baseA_q   <= '0;
            baseB_q   <= '0;
            baseC_q   <= '0;
            opData_q  <= '0;
            opSel_q   <= OP_SEL_A;
            opIndex_q <= '0;
            resWord_q <= '0;
            memAddr_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            baseA_q   <= baseA_d;
            baseB_q   <= baseB_d;
            baseC_q   <= baseC_d;
            opData_q  <= opData_d;
            opSel_q   <= opSel_d;
            opIndex_q <= opIndex_d;
            resWord_q <= resWord_d;
            memAddr_q <= memAddr_d;
        end
    end

    // Status and channel outputs are decoded straight from the state, so
    // write enable and res_ready can only ever be high in their own state.
    assign busy                  = (state_q != ST_IDLE);
    assign done                  = (state_q == ST_DONE);
    assign bus.op_valid          = (state_q == ST_RD_OUT);
    assign bus.op_data           = opData_q;
    assign bus.op_sel            = opSel_q;
    assign bus.op_index          = opIndex_q;
    assign bus.res_ready         = (state_q == ST_WR_ACC);
    assign bus.mem_write_readBar = (state_q == ST_WR_MEM);
    assign bus.mem_address       = memAddr_d;
    assign bus.mem_wdata         = resWord_q;

endmodule

// File: tb/tb_matrix_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_matrix_mem_controller
//
// Self-checking bench: a behavioural memory, a randomised multiplier on the
// operand/result channels, and a reference model that predicts the operand
// stream as two memory windows and the write-back as one memory window.
// ---------------------------------------------------------------------------
module tb_matrix_mem_controller;
    import matrix_mem_pkg::*;

    localparam int DIM      = 4;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int WORDS    = DIM * DIM;
    localparam int MEM_SIZE = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_c;
    logic              busy;
    logic              done;

    matrix_mem_controller_if #(.DIM(DIM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    matrix_mem_controller #(.DIM(DIM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .base_a (base_a),
        .base_b (base_b),
        .base_c (base_c),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Main memory: registered read (data the cycle after the address), one
    // write per cycle, plus a preload path used only while the DUT is idle.
    logic [DATA_W-1:0] tbMem [MEM_SIZE];
    logic              preloadEn;
    logic [ADDR_W-1:0] preloadAddr;
    logic [DATA_W-1:0] preloadData;

    always @(posedge clk) begin
        if (preloadEn) begin
            tbMem[preloadAddr] <= preloadData;
        end else if (bus.mem_write_readBar) begin
            tbMem[bus.mem_address] <= bus.mem_wdata;
        end
        bus.mem_rdata <= tbMem[bus.mem_address];
    end

    int checkCount = 0;
    int errorCount = 0;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic preloadWord(input int addr, input logic [DATA_W-1:0] data);
        preloadAddr = ADDR_W'(addr);
        preloadData = data;
        preloadEn   = 1'b1;
        @(negedge clk);
        preloadEn   = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},      busy, 0);
        checkOutput({tag, "_done"},      done, 0);
        checkOutput({tag, "_opValid"},   bus.op_valid, 0);
        checkOutput({tag, "_opData"},    bus.op_data, 0);
        checkOutput({tag, "_opSel"},     bus.op_sel, 0);
        checkOutput({tag, "_opIndex"},   bus.op_index, 0);
        checkOutput({tag, "_resReady"},  bus.res_ready, 0);
        checkOutput({tag, "_memWrite"},  bus.mem_write_readBar, 0);
        checkOutput({tag, "_memAddr"},   bus.mem_address, 0);
        checkOutput({tag, "_memWdata"},  bus.mem_wdata, 0);
    endtask

    // Runs one full operation (or aborts it with a reset at operand resetAt).
    // stallIdx/stallLen force op_ready low on one operand; busyStartAt pulses
    // start with different bases at that cycle of the operation.
    task automatic applyStimulus(input int ba, input int bb, input int bc,
                                 input int readyPct, input int validPct,
                                 input int stallIdx, input int stallLen,
                                 input int resetAt, input int busyStartAt,
                                 input bit seqResults);
        logic [DATA_W-1:0] expOp   [2*WORDS];
        int                expAddr [2*WORDS];
        logic [DATA_W-1:0] resWords[WORDS];
        int  cycle, n, w, r, doneCnt, stallCnt, firstValid;
        bit  prevStall, prevDone, finished, aborted, resHeld;
        logic [DATA_W-1:0] prevData;
        logic              prevSel;
        logic [3:0]        prevIdx;
        logic [ADDR_W-1:0] prevAddr;

        for (int i = 0; i < 2*WORDS; i++) begin
            expAddr[i] = ((i < WORDS ? ba : bb) + (i % WORDS)) % MEM_SIZE;
            expOp[i]   = tbMem[expAddr[i]];
        end
        for (int i = 0; i < WORDS; i++) begin
            resWords[i] = seqResults ? DATA_W'(100 + i) : $urandom;
        end

        n = 0; w = 0; r = 0; doneCnt = 0; stallCnt = 0; firstValid = -1;
        prevStall = 0; prevDone = 0; finished = 0; aborted = 0; resHeld = 0;
        prevData = '0; prevSel = 0; prevIdx = '0; prevAddr = '0;

        base_a = ADDR_W'(ba);
        base_b = ADDR_W'(bb);
        base_c = ADDR_W'(bc);
        start  = 1'b1;
        @(posedge clk);
        cycle = 0;

        while (!finished && cycle < 3000) begin
            @(negedge clk);
            cycle++;
            if (cycle == 1) begin
                start = 1'b0;
                checkOutput("busyAfterStart", busy, 1);
                checkOutput("noEarlyValid", bus.op_valid, 0);
            end
            if (busyStartAt > 0 && cycle == busyStartAt) begin
                start  = 1'b1;
                base_a = ADDR_W'(ba + 7);
                base_b = ADDR_W'(bb + 9);
                base_c = ADDR_W'(bc + 11);
            end else if (busyStartAt > 0 && cycle == busyStartAt + 1) begin
                start = 1'b0;
            end

            if (prevDone) begin
                checkOutput("busyAfterDone", busy, 0);
                checkOutput("donePulseWidth", done, 0);
                finished = 1;
                continue;
            end

            if (prevStall) begin
                checkOutput("validHeld", bus.op_valid, 1);
                checkOutput("stallData", bus.op_data, prevData);
                checkOutput("stallSel", bus.op_sel, prevSel);
                checkOutput("stallIndex", bus.op_index, prevIdx);
                checkOutput("stallAddr", bus.mem_address, prevAddr);
                checkOutput("stallNoWrite", bus.mem_write_readBar, 0);
            end

            if (bus.op_valid) begin
                if (firstValid < 0) begin
                    firstValid = cycle;
                    checkOutput("firstValidLatency", cycle, 3);
                end
                if (resetAt >= 0 && n == resetAt) begin
                    bus.op_ready  = 1'b0;
                    bus.res_valid = 1'b0;
                    reset = 1'b1;
                    @(negedge clk);
                    checkResetOutputs("midReset");
                    reset = 1'b0;
                    aborted  = 1;
                    finished = 1;
                    continue;
                end
                if (n == stallIdx && stallCnt < stallLen) begin
                    bus.op_ready = 1'b0;
                    stallCnt++;
                end else begin
                    bus.op_ready = ($urandom_range(99) < readyPct);
                end
                if (bus.op_ready) begin
                    if (n < 2*WORDS) begin
                        checkOutput("opData", bus.op_data, expOp[n]);
                        checkOutput("opSel", bus.op_sel, (n >= WORDS) ? 1 : 0);
                        checkOutput("opIndex", bus.op_index, n % WORDS);
                        checkOutput("readAddr", bus.mem_address, expAddr[n]);
                    end else begin
                        checkOutput("extraOperand", n, 2*WORDS - 1);
                    end
                    n++;
                    prevStall = 0;
                end else begin
                    prevStall = 1;
                    prevData  = bus.op_data;
                    prevSel   = bus.op_sel;
                    prevIdx   = bus.op_index;
                    prevAddr  = bus.mem_address;
                end
            end else begin
                bus.op_ready = 1'($urandom_range(1));
                prevStall    = 0;
            end

            if (!resHeld) begin
                if (r < WORDS && $urandom_range(99) < validPct) begin
                    bus.res_valid = 1'b1;
                    bus.res_data  = resWords[r];
                    resHeld       = 1;
                end else begin
                    bus.res_valid = 1'b0;
                    bus.res_data  = $urandom;
                end
            end
            if (resHeld && bus.res_ready) begin
                r++;
                resHeld = 0;
            end

            if (bus.mem_write_readBar) begin
                if (w < WORDS) begin
                    checkOutput("writeAddr", bus.mem_address, (bc + w) % MEM_SIZE);
                    checkOutput("writeData", bus.mem_wdata, resWords[w]);
                end else begin
                    checkOutput("extraWrite", w, WORDS - 1);
                end
                w++;
            end

            if (done) begin
                doneCnt++;
                prevDone = 1;
            end
        end

        bus.res_valid = 1'b0;
        checkOutput("noTimeout", finished, 1);
        if (!aborted) begin
            checkOutput("operandCount", n, 2*WORDS);
            checkOutput("writeCount", w, WORDS);
            checkOutput("doneCount", doneCnt, 1);
            for (int i = 0; i < WORDS; i++) begin
                checkOutput("memC", tbMem[(bc + i) % MEM_SIZE], resWords[i]);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        base_a        = '0;
        base_b        = '0;
        base_c        = '0;
        preloadEn     = 1'b0;
        preloadAddr   = '0;
        preloadData   = '0;
        bus.op_ready  = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b0;

        for (int i = 0; i < MEM_SIZE; i++) preloadWord(i, $urandom);
        for (int i = 0; i < WORDS; i++) begin
            preloadWord(16 + i, DATA_W'(i + 1));
            preloadWord(32 + i, DATA_W'(i + 17));
        end

        $display("[TB] nominal read + gapped write-back");
        applyStimulus(16, 32, 64, 100, 50, -1, 0, -1, 0, 1'b1);

        $display("[TB] backpressure on A[3]");
        applyStimulus(16, 32, 64, 100, 100, 3, 5, -1, 0, 1'b1);

        $display("[TB] address wrap");
        applyStimulus(1020, 500, 200, 70, 60, -1, 0, -1, 0, 1'b0);

        $display("[TB] reset during A[5] then restart");
        applyStimulus(16, 32, 300, 100, 100, -1, 0, 5, 0, 1'b0);
        applyStimulus(16, 32, 300, 100, 100, -1, 0, -1, 0, 1'b0);

        $display("[TB] start pulsed while busy");
        applyStimulus(100, 150, 700, 80, 70, -1, 0, -1, 10, 1'b0);
        applyStimulus(1010, 1015, 1020, 60, 50, -1, 0, -1, 60, 1'b0);

        $display("[TB] random operations");
        for (int t = 0; t < 3; t++) begin
            applyStimulus($urandom_range(MEM_SIZE - 1), $urandom_range(MEM_SIZE - 1),
                          $urandom_range(MEM_SIZE - 1), $urandom_range(30, 100),
                          $urandom_range(30, 100), $urandom_range(2*WORDS - 1),
                          $urandom_range(4), -1, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
